// File: rtl/pcie_rr_lock_arbiter_pkg.sv
// Shared types and sizing helpers for the PCIe TX round-robin lock arbiter.
package pcie_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   localparam int DEF_TIMEOUT_W = 8;
   localparam int DEF_WEIGHT_W  = 4;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pcie_rr_lock_arbiter_if.sv
// Request/grant bundle between packet sources and the arbiter.
// The weight field exists only when ARB_WEIGHT_EN is defined.
interface pcie_rr_lock_arbiter_if
   import pcie_arb_pkg::*;
#(
   parameter int NUM_REQ  = 8,
   parameter int WEIGHT_W = DEF_WEIGHT_W
);
   localparam int IDX_W = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] req_last;
   logic               gnt_ready;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid;
   logic               busy;
   logic               timeout_err;

   if (NUM_REQ < 2 || NUM_REQ > 32 || WEIGHT_W < 1) begin : g_cfg_check
      $error("pcie_rr_lock_arbiter_if: unsupported NUM_REQ/WEIGHT_W");
   end

`ifdef ARB_WEIGHT_EN
   logic [NUM_REQ*WEIGHT_W-1:0] weight;

   modport master (
      output req, req_last, gnt_ready, weight,
      input  gnt, gnt_idx, gnt_valid, busy, timeout_err
   );

   modport slave (
      input  req, req_last, gnt_ready, weight,
      output gnt, gnt_idx, gnt_valid, busy, timeout_err
   );
`else
   modport master (
      output req, req_last, gnt_ready,
      input  gnt, gnt_idx, gnt_valid, busy, timeout_err
   );

   modport slave (
      input  req, req_last, gnt_ready,
      output gnt, gnt_idx, gnt_valid, busy, timeout_err
   );
`endif

endinterface

// File: rtl/pcie_rr_lock_arbiter_pick.sv
// Combinational round-robin picker: first set bit of req strictly above
// pointer, wrapping around to the lowest index.
module rr_pick_onehot
   import pcie_arb_pkg::*;
#(
   parameter int NUM_REQ = 8,
   parameter int IDX_W   = idx_width(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   pick_idx,
   output logic               any
);

   logic [NUM_REQ-1:0]   above_mask;
   logic [2*NUM_REQ-1:0] dbl;
   logic [2*NUM_REQ-1:0] iso;

   always_comb begin
      above_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         above_mask[i] = (i > int'(pointer));
      end
   end

   // Low half holds only bits above the pointer; the unmasked upper copy
   // supplies the wrapped-around choice when nothing is set above it.
   assign dbl  = {req, req & above_mask};
   assign iso  = dbl & (-dbl);
   assign pick = iso[NUM_REQ-1:0] | iso[2*NUM_REQ-1:NUM_REQ];
   assign any  = |req;

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/pcie_rr_lock_arbiter.sv
// Registered round-robin arbiter with per-packet grant lock, same-edge
// handover and lock watchdog. Optional weighting under ARB_WEIGHT_EN.
module pcie_rr_lock_arbiter
   import pcie_arb_pkg::*;
#(
   parameter int NUM_REQ   = 8,
   parameter int TIMEOUT_W = DEF_TIMEOUT_W,
   parameter int WEIGHT_W  = DEF_WEIGHT_W
)(
   input  logic                   clk,
   input  logic                   rst,
   pcie_rr_lock_arbiter_if.slave  arb
);

   localparam int IDX_W = idx_width(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 32 || TIMEOUT_W < 1 || WEIGHT_W < 1) begin : g_cfg_check
      $error("pcie_rr_lock_arbiter: unsupported parameters");
   end

   arb_state_t          state;
   logic [NUM_REQ-1:0]  gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic [IDX_W-1:0]    pointer;
   logic [TIMEOUT_W-1:0] wd_cnt;
   logic                timeout_err;

   logic                gnt_valid;
   logic                accept;
   logic                release_pkt;
   logic                wd_expire;
   logic                hold_grant;
   logic                rotate;

   logic [NUM_REQ-1:0]  pick_req;
   logic [IDX_W-1:0]    pick_ptr;
   logic [NUM_REQ-1:0]  pick;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;

   assign gnt_valid   = |(gnt & arb.req);
   assign accept      = gnt_valid & arb.gnt_ready;
   assign release_pkt = accept & (|(gnt & arb.req_last));
   // Forced release on the edge at which the counter already holds all-ones.
   assign wd_expire   = (state == LOCK) & ~accept & (&wd_cnt);
   assign rotate      = (release_pkt & ~hold_grant) | wd_expire;

   // While locked the current owner is masked out, so a handover only goes
   // to another source; a lone requester re-enters through IDLE.
   assign pick_req = (state == LOCK) ? (arb.req & ~gnt) : arb.req;
   assign pick_ptr = (state == LOCK) ? gnt_idx : pointer;

   rr_pick_onehot #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req      (pick_req),
      .pointer  (pick_ptr),
      .pick     (pick),
      .pick_idx (pick_idx),
      .any      (pick_any)
   );

`ifdef ARB_WEIGHT_EN
   logic [WEIGHT_W-1:0] pkt_cnt;
   logic [WEIGHT_W-1:0] cur_weight;
   logic [WEIGHT_W-1:0] eff_weight;

   always_comb begin
      cur_weight = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) cur_weight = arb.weight[i*WEIGHT_W +: WEIGHT_W];
      end
   end

   assign eff_weight = (cur_weight == '0) ? WEIGHT_W'(1) : cur_weight;
   // release_pkt implies the owner's request is still asserted.
   assign hold_grant = release_pkt &
                       (((WEIGHT_W+1)'(pkt_cnt) + (WEIGHT_W+1)'(1)) < (WEIGHT_W+1)'(eff_weight));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt <= '0;
      end else if (state != LOCK || rotate) begin
         pkt_cnt <= '0;
      end else if (hold_grant) begin
         pkt_cnt <= pkt_cnt + WEIGHT_W'(1);
      end
   end
`else
   assign hold_grant = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         gnt         <= '0;
         gnt_idx     <= '0;
         pointer     <= IDX_W'(NUM_REQ-1);
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= wd_expire;
         case (state)
            IDLE: begin
               wd_cnt <= '0;
               if (pick_any) begin
                  state   <= LOCK;
                  gnt     <= pick;
                  gnt_idx <= pick_idx;
               end
            end
            LOCK: begin
               if (rotate) begin
                  pointer <= gnt_idx;
                  wd_cnt  <= '0;
                  if (pick_any) begin
                     gnt     <= pick;
                     gnt_idx <= pick_idx;
                  end else begin
                     state <= IDLE;
                     gnt   <= '0;
                  end
               end else if (accept) begin
                  wd_cnt <= '0;
               end else begin
                  wd_cnt <= wd_cnt + TIMEOUT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign arb.gnt         = gnt;
   assign arb.gnt_idx     = gnt_idx;
   assign arb.gnt_valid   = gnt_valid;
   assign arb.busy        = (state == LOCK);
   assign arb.timeout_err = timeout_err;

endmodule

// File: tb/tb_pcie_rr_lock_arbiter.sv
// Scoreboard bench for pcie_rr_lock_arbiter: directed scenarios plus random
// traffic, predicted by a source-level round-robin model.
module tb_pcie_rr_lock_arbiter;

   localparam int N        = 4;
   localparam int TW       = 3;
   localparam int WW       = 4;
   localparam int WD_LIMIT = (1 << TW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pcie_rr_lock_arbiter_if #(.NUM_REQ(N), .WEIGHT_W(WW)) bus ();

   pcie_rr_lock_arbiter #(
      .NUM_REQ   (N),
      .TIMEOUT_W (TW),
      .WEIGHT_W  (WW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .arb (bus)
   );

   typedef struct {
      logic [N-1:0] gnt;
      logic [1:0]   idx;
      logic         busy;
      logic         terr;
      logic         valid;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   errors = 0;

   // Reference model: owner (-1 = none), last served source, idle cycles
   // under lock, packets served in the current turn, per-source weight.
   int owner;
   int ptr;
   int idle_cnt;
   int served;
   bit terr_m;
   int wt[N];

   function automatic void model_reset();
      owner    = -1;
      ptr      = N - 1;
      idle_cnt = 0;
      served   = 0;
      terr_m   = 1'b0;
   endfunction

   function automatic int next_owner(input logic [N-1:0] r, input int from, input int excl);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (from + k) % N;
         if (c != excl && r[c]) return c;
      end
      return -1;
   endfunction

   function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
      bit acc, done, tout;
      int w;
      terr_m = 1'b0;
      if (owner < 0) begin
         owner    = next_owner(r, ptr, -1);
         idle_cnt = 0;
         served   = 0;
         return;
      end
      acc  = r[owner] && rdy;
      done = acc && l[owner];
      tout = !acc && (idle_cnt == WD_LIMIT);
      if (!done && !tout) begin
         idle_cnt = acc ? 0 : idle_cnt + 1;
         return;
      end
      idle_cnt = 0;
      terr_m   = tout;
      w = (wt[owner] == 0) ? 1 : wt[owner];
      if (done && served + 1 < w) begin
         served++;
         return;
      end
      ptr    = owner;
      served = 0;
      owner  = next_owner(r, ptr, ptr);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic set_weights();
`ifdef ARB_WEIGHT_EN
      for (int i = 0; i < N; i++) bus.weight[i*WW +: WW] = WW'(wt[i]);
`endif
   endtask

   // One clock cycle of stimulus; the expectation for this cycle is queued
   // before the model advances across the next edge.
   task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy, input bit do_rst);
      exp_t e;
      @(posedge clk);
      #2;
      bus.req       = r;
      bus.req_last  = l;
      bus.gnt_ready = rdy;
      if (do_rst) begin
         rst = 1'b1;
         model_reset();
      end else begin
         rst = 1'b0;
      end
      e.gnt   = (owner < 0) ? '0 : N'(1 << owner);
      e.idx   = (owner < 0) ? 2'd0 : 2'(owner);
      e.busy  = (owner >= 0);
      e.terr  = terr_m;
      e.valid = (owner >= 0) && r[owner];
      exp_q.push_back(e);
      if (!do_rst) model_step(r, l, rdy);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0) continue;
         e = exp_q.pop_front();
         check("gnt", 32'(bus.gnt), 32'(e.gnt));
         check("busy", 32'(bus.busy), 32'(e.busy));
         check("timeout_err", 32'(bus.timeout_err), 32'(e.terr));
         check("gnt_valid", 32'(bus.gnt_valid), 32'(e.valid));
         if (e.gnt != '0) check("gnt_idx", 32'(bus.gnt_idx), 32'(e.idx));
      end
   end

   initial begin : stimulus
      logic [N-1:0] r;
      int ready_pct;
      bus.req       = '0;
      bus.req_last  = '0;
      bus.gnt_ready = 1'b0;
      model_reset();
      for (int i = 0; i < N; i++) wt[i] = 1;
      set_weights();

      // Back-to-back single-beat packets from all sources.
      repeat (6) cycle(4'b1111, 4'b1111, 1'b1, 1'b0);

      // Multi-beat packet with stalls, then handover to source 2.
      cycle('0, '0, 1'b0, 1'b1);
      cycle(4'b0101, 4'b0000, 1'b1, 1'b0);
      cycle(4'b0101, 4'b0000, 1'b1, 1'b0);
      cycle(4'b0101, 4'b0000, 1'b0, 1'b0);
      cycle(4'b0101, 4'b0000, 1'b1, 1'b0);
      cycle(4'b0101, 4'b0001, 1'b1, 1'b0);
      repeat (2) cycle(4'b0100, 4'b0100, 1'b1, 1'b0);

      // Owner drops its request mid-packet.
      cycle('0, '0, 1'b0, 1'b1);
      cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
      repeat (3) cycle(4'b1001, 4'b0000, 1'b1, 1'b0);
      cycle(4'b1011, 4'b0010, 1'b1, 1'b0);

      // Watchdog: locked with no accepts.
      cycle('0, '0, 1'b0, 1'b1);
      repeat (20) cycle(4'b1010, 4'b0000, 1'b0, 1'b0);

      // Asynchronous reset mid-packet, then a fresh search from index 0.
      repeat (3) cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
      cycle(4'b0100, 4'b0000, 1'b0, 1'b1);
      repeat (3) cycle(4'b1111, 4'b1111, 1'b1, 1'b0);

      // Single requester pays one bubble per packet.
      repeat (6) cycle(4'b0001, 4'b0001, 1'b1, 1'b0);

`ifdef ARB_WEIGHT_EN
      wt[0] = 3;
      set_weights();
      cycle('0, '0, 1'b0, 1'b1);
      repeat (8) cycle(4'b0011, 4'b0011, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) wt[i] = $urandom_range(0, 3);
      set_weights();
`endif

      r = '0;
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] flip;
         ready_pct = ((c / 250) % 3 == 1) ? 10 : 75;
         flip = '0;
         for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 7) == 0);
         r = r ^ flip;
         cycle(r, N'($urandom), ($urandom_range(0, 99) < ready_pct), ($urandom_range(0, 399) == 0));
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      check("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
